// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder sitting between fetch and execute.
// One pipeline register with a valid/ready handshake, flush and stall.
// FENCE, SYSTEM and every malformed encoding are reported through 'illegal'.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      alu_op,
    output logic            alu_sign,
    output logic [1:0]      a_sel,
    output logic [1:0]      b_sel,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic [2:0]      mem_funct3,
    output logic            illegal
);

    // Full 7-bit opcodes; bits [1:0] are part of the match, so any word whose
    // low bits are not 11 falls through to the illegal default.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic            alu_sign;
        logic [1:0]      a_sel;
        logic [1:0]      b_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [2:0]      mem_funct3;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } bundle_t;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm32_s;
    bundle_t     dec_s;
    bundle_t     bundle_r;
    logic        valid_r;
    logic        capture_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];

    assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s = {instr[31:12], 12'h000};
    assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // No skid buffer: accept whenever the register is empty or being drained.
    assign in_ready  = !valid_r || out_ready;
    // Flush wins over capture; the instruction offered alongside it is dropped.
    assign capture_s = in_valid && in_ready && !flush;

    // Decode the incoming word into the control bundle, then gate side effects.
    always_comb begin
        dec_s            = '0;
        imm32_s          = 32'h0000_0000;
        dec_s.rs1        = instr[19:15];
        dec_s.rs2        = instr[24:20];
        dec_s.rd         = instr[11:7];
        dec_s.mem_funct3 = funct3_s;
        dec_s.pc         = pc;
        case (opcode_s)
            OPC_OP: begin
                dec_s.alu_op    = funct3_s;
                dec_s.alu_sign  = instr[30];
                dec_s.b_sel     = B_RS2;
                dec_s.reg_write = 1'b1;
                dec_s.illegal   = !((funct7_s == 7'h00) ||
                                    ((funct7_s == 7'h20) &&
                                     ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
            end
            OPC_OP_IMM: begin
                dec_s.alu_op    = funct3_s;
                // Only shifts carry a sign bit; a negative ADDI/SLTI immediate must not.
                dec_s.alu_sign  = (funct3_s == 3'b101) ? instr[30] : 1'b0;
                dec_s.b_sel     = B_IMM;
                dec_s.reg_write = 1'b1;
                imm32_s         = imm_i_s;
                case (funct3_s)
                    3'b001:  dec_s.illegal = (funct7_s != 7'h00);
                    3'b101:  dec_s.illegal = !((funct7_s == 7'h00) || (funct7_s == 7'h20));
                    default: dec_s.illegal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_s.b_sel     = B_IMM;
                dec_s.mem_read  = 1'b1;
                dec_s.reg_write = 1'b1;
                imm32_s         = imm_i_s;
                dec_s.illegal   = (funct3_s == 3'b011) || (funct3_s == 3'b110) ||
                                  (funct3_s == 3'b111);
            end
            OPC_STORE: begin
                dec_s.b_sel     = B_IMM;
                dec_s.mem_write = 1'b1;
                imm32_s         = imm_s_s;
                dec_s.illegal   = (funct3_s >= 3'b011);
            end
            OPC_BRANCH: begin
                dec_s.branch = 1'b1;
                dec_s.b_sel  = B_RS2;
                imm32_s      = imm_b_s;
                case (funct3_s)
                    3'b000, 3'b001: begin
                        dec_s.alu_op   = 3'b000;
                        dec_s.alu_sign = 1'b1;
                    end
                    3'b100, 3'b101: dec_s.alu_op = 3'b010;
                    3'b110, 3'b111: dec_s.alu_op = 3'b011;
                    default:        dec_s.illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_s.a_sel     = A_ZERO;
                dec_s.b_sel     = B_IMM;
                dec_s.reg_write = 1'b1;
                imm32_s         = imm_u_s;
            end
            OPC_AUIPC: begin
                dec_s.a_sel     = A_PC;
                dec_s.b_sel     = B_IMM;
                dec_s.reg_write = 1'b1;
                imm32_s         = imm_u_s;
            end
            OPC_JAL: begin
                dec_s.a_sel     = A_PC;
                dec_s.b_sel     = B_FOUR;
                dec_s.jump      = 1'b1;
                dec_s.reg_write = 1'b1;
                imm32_s         = imm_j_s;
            end
            OPC_JALR: begin
                dec_s.a_sel     = A_PC;
                dec_s.b_sel     = B_FOUR;
                dec_s.jump      = 1'b1;
                dec_s.reg_write = 1'b1;
                imm32_s         = imm_i_s;
                dec_s.illegal   = (funct3_s != 3'b000);
            end
            default: begin
                dec_s.a_sel   = A_RS1;
                dec_s.illegal = 1'b1;
            end
        endcase
        dec_s.imm       = XLEN'($signed(imm32_s));
        // An illegal word must have no architectural side effect; x0 is never written.
        dec_s.reg_write = dec_s.reg_write & ~dec_s.illegal & (dec_s.rd != 5'd0);
        dec_s.mem_read  = dec_s.mem_read  & ~dec_s.illegal;
        dec_s.mem_write = dec_s.mem_write & ~dec_s.illegal;
        dec_s.branch    = dec_s.branch    & ~dec_s.illegal;
        dec_s.jump      = dec_s.jump      & ~dec_s.illegal;
    end

    // Valid flag: flush clears, capture sets, a drain with nothing behind clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (capture_s) begin
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Datapath register loads only on capture, so a stall keeps it bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_r <= '0;
        end else if (capture_s) begin
            bundle_r <= dec_s;
        end else begin
            bundle_r <= bundle_r;
        end
    end

    assign out_valid  = valid_r;
    assign out_pc     = bundle_r.pc;
    assign alu_op     = bundle_r.alu_op;
    assign alu_sign   = bundle_r.alu_sign;
    assign a_sel      = bundle_r.a_sel;
    assign b_sel      = bundle_r.b_sel;
    assign imm        = bundle_r.imm;
    assign rs1        = bundle_r.rs1;
    assign rs2        = bundle_r.rs2;
    assign rd         = bundle_r.rd;
    assign reg_write  = bundle_r.reg_write;
    assign mem_read   = bundle_r.mem_read;
    assign mem_write  = bundle_r.mem_write;
    assign branch     = bundle_r.branch;
    assign jump       = bundle_r.jump;
    assign mem_funct3 = bundle_r.mem_funct3;
    assign illegal    = bundle_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table of hand-decoded RV32I words pushed through the stage
// with a scoreboard queue, plus stall, flush and asynchronous-reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  alu_op;
    logic        alu_sign;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [2:0]  mem_funct3;
    logic        illegal;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .alu_op(alu_op), .alu_sign(alu_sign),
        .a_sel(a_sel), .b_sel(b_sel), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .mem_funct3(mem_funct3), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  op;
        logic        sg;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] im;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  d;
        logic [4:0]  flags;   // reg_write, mem_read, mem_write, branch, jump
        logic [2:0]  f3;
        logic        il;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];
    vec_t sb [$];
    vec_t cur;
    logic mv;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic [2:0] op, input logic sg,
                                input logic [1:0] a, input logic [1:0] b, input logic [31:0] im,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                input logic [4:0] flags, input logic [2:0] f3, input logic il);
        vec_t v;
        v.instr = i; v.pc = 32'h0; v.op = op; v.sg = sg; v.a = a; v.b = b; v.im = im;
        v.r1 = r1; v.r2 = r2; v.d = d; v.flags = flags; v.f3 = f3; v.il = il;
        return v;
    endfunction

    function automatic logic [63:0] act_ctl();
        return {8'd0, out_pc, rs1, rs2, rd, reg_write, mem_read, mem_write, branch, jump,
                mem_funct3, illegal};
    endfunction

    function automatic logic [63:0] act_dp();
        return {24'd0, alu_op, alu_sign, a_sel, b_sel, imm};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_out(input vec_t e);
        check($sformatf("ctl[%h]", e.instr), act_ctl(),
              {8'd0, e.pc, e.r1, e.r2, e.d, e.flags, e.f3, e.il});
        if (!e.il) begin
            check($sformatf("dp[%h]", e.instr), act_dp(), {24'd0, e.op, e.sg, e.a, e.b, e.im});
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({name, "_ctl"}, act_ctl(), 64'd0);
        check({name, "_dp"}, act_dp(), 64'd0);
    endtask

    task automatic drive(input vec_t v);
        cur      = v;
        instr    = v.instr;
        pc       = v.pc;
        in_valid = 1'b1;
    endtask

    // One cycle: check at the falling edge, update the model, advance past the rising edge.
    task automatic step();
        logic xfer;
        logic acc;
        @(negedge clk);
        check("out_valid", {63'd0, out_valid}, {63'd0, mv});
        check("in_ready", {63'd0, in_ready}, {63'd0, (!mv || out_ready)});
        if (mv) begin
            check("sb_nonempty", {63'd0, (sb.size() != 0)}, 64'd1);
            if (sb.size() != 0) begin
                compare_out(sb[0]);
            end
        end
        xfer = mv && out_ready;
        acc  = in_valid && (!mv || out_ready) && !flush;
        if (mv && (xfer || flush) && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (acc) begin
            sb.push_back(cur);
        end
        mv = flush ? 1'b0 : (acc ? 1'b1 : (xfer ? 1'b0 : mv));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8 && (mv || sb.size() != 0); k++) begin
            step();
        end
        step();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr = 32'h0; pc = 32'h0; mv = 1'b0;

        //            instr          op    sg    a      b      imm            rs1    rs2    rd     flags     f3    il
        tbl[0]  = mk(32'hFFF00093, 3'd0, 1'b0, 2'd0, 2'd1, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd1,  5'b10000, 3'd0, 1'b0); // ADDI -1
        tbl[1]  = mk(32'h402081B3, 3'd0, 1'b1, 2'd0, 2'd0, 32'h00000000, 5'd1,  5'd2,  5'd3,  5'b10000, 3'd0, 1'b0); // SUB
        tbl[2]  = mk(32'h4032D293, 3'd5, 1'b1, 2'd0, 2'd1, 32'h00000403, 5'd5,  5'd3,  5'd5,  5'b10000, 3'd5, 1'b0); // SRAI
        tbl[3]  = mk(32'h00208463, 3'd0, 1'b1, 2'd0, 2'd0, 32'h00000008, 5'd1,  5'd2,  5'd8,  5'b00010, 3'd0, 1'b0); // BEQ +8
        tbl[4]  = mk(32'h0000006F, 3'd0, 1'b0, 2'd1, 2'd2, 32'h00000000, 5'd0,  5'd0,  5'd0,  5'b00001, 3'd0, 1'b0); // JAL x0
        tbl[5]  = mk(32'h00000000, 3'd0, 1'b0, 2'd0, 2'd0, 32'h00000000, 5'd0,  5'd0,  5'd0,  5'b00000, 3'd0, 1'b1); // all zero
        tbl[6]  = mk(32'hFFFFFFFF, 3'd0, 1'b0, 2'd0, 2'd0, 32'h00000000, 5'd31, 5'd31, 5'd31, 5'b00000, 3'd7, 1'b1); // all ones
        tbl[7]  = mk(32'h40109093, 3'd0, 1'b0, 2'd0, 2'd0, 32'h00000000, 5'd1,  5'd1,  5'd1,  5'b00000, 3'd1, 1'b1); // SLLI f7=20
        tbl[8]  = mk(32'hFFC12283, 3'd0, 1'b0, 2'd0, 2'd1, 32'hFFFFFFFC, 5'd2,  5'd28, 5'd5,  5'b11000, 3'd2, 1'b0); // LW -4
        tbl[9]  = mk(32'h0063A423, 3'd0, 1'b0, 2'd0, 2'd1, 32'h00000008, 5'd7,  5'd6,  5'd8,  5'b00100, 3'd2, 1'b0); // SW 8
        tbl[10] = mk(32'h12345537, 3'd0, 1'b0, 2'd2, 2'd1, 32'h12345000, 5'd8,  5'd3,  5'd10, 5'b10000, 3'd5, 1'b0); // LUI
        tbl[11] = mk(32'hFFFFF097, 3'd0, 1'b0, 2'd1, 2'd1, 32'hFFFFF000, 5'd31, 5'd31, 5'd1,  5'b10000, 3'd7, 1'b0); // AUIPC
        tbl[12] = mk(32'h004100E7, 3'd0, 1'b0, 2'd1, 2'd2, 32'h00000004, 5'd2,  5'd4,  5'd1,  5'b10001, 3'd0, 1'b0); // JALR
        tbl[13] = mk(32'hFE41EEE3, 3'd3, 1'b0, 2'd0, 2'd0, 32'hFFFFFFFC, 5'd3,  5'd4,  5'd29, 5'b00010, 3'd6, 1'b0); // BLTU -4
        tbl[14] = mk(32'h00208033, 3'd0, 1'b0, 2'd0, 2'd0, 32'h00000000, 5'd1,  5'd2,  5'd0,  5'b00000, 3'd0, 1'b0); // ADD x0
        tbl[15] = mk(32'h00002063, 3'd0, 1'b0, 2'd0, 2'd0, 32'h00000000, 5'd0,  5'd0,  5'd0,  5'b00000, 3'd2, 1'b1); // branch f3=010
        tbl[16] = mk(32'hFFF0A093, 3'd2, 1'b0, 2'd0, 2'd1, 32'hFFFFFFFF, 5'd1,  5'd31, 5'd1,  5'b10000, 3'd2, 1'b0); // SLTI -1
        tbl[17] = mk(32'h4020D1B3, 3'd5, 1'b1, 2'd0, 2'd0, 32'h00000000, 5'd1,  5'd2,  5'd3,  5'b10000, 3'd5, 1'b0); // SRA
        tbl[18] = mk(32'h0000000F, 3'd0, 1'b0, 2'd0, 2'd0, 32'h00000000, 5'd0,  5'd0,  5'd0,  5'b00000, 3'd0, 1'b1); // FENCE
        tbl[19] = mk(32'h00003023, 3'd0, 1'b0, 2'd0, 2'd0, 32'h00000000, 5'd0,  5'd0,  5'd0,  5'b00000, 3'd3, 1'b1); // store f3=011
        for (int i = 0; i < NV; i++) begin
            tbl[i].pc = 32'h0000_1000 + 32'(i * 4);
        end

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;

        // Full-throughput pass over the whole table.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            step();
        end
        drain();

        // Backpressure: three stalled cycles, then back-to-back transfers.
        drive(tbl[0]);
        step();
        out_ready = 1'b0;
        drive(tbl[1]);
        repeat (3) step();
        out_ready = 1'b1;
        step();
        drive(tbl[2]);
        step();
        drive(tbl[3]);
        step();
        drain();

        // Flush while holding a bundle and offered a new one.
        drive(tbl[8]);
        step();
        out_ready = 1'b0;
        drive(tbl[9]);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        drive(tbl[10]);
        step();
        drain();

        // Asynchronous reset in the middle of a stall.
        drive(tbl[11]);
        step();
        out_ready = 1'b0;
        drive(tbl[12]);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_stall_reset");
        sb.delete();
        mv = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset("held_reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(tbl[13]);
        step();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
